adder64_seq_ctrl: RTL and testbench

Area-reduced 64-bit add/subtract unit built around one shared Adder16bit slice, which it runs over NSLICE consecutive cycles. The block latches the operands on a valid/ready accept. Each cycle it feeds one 16-bit slice and its registered carry through Adder16bit, and it assembles Sum in a result register. The block sits between the execute-stage issue logic and writeback, and is used where the combinational 64-bit ripple adder is too slow or too large.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/Adder16bit.sv | 13 +
 rtl/adder64_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_adder64_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants, FSM encoding and slice-count helper for the
// sequential 64-bit add/subtract unit.
package adder_pkg;

  localparam int SLICE_W   = 16;
  localparam int WIDTH_DEF = 64;

  function automatic int nslice(input int w);
    return w / SLICE_W;
  endfunction

  localparam int NSLICE = nslice(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Adder16bit.sv
// 16-bit ripple slice: Sum/Co = A + B + Ci.
// Ports: A, B (16b), Ci -> Sum (16b), Co.
module Adder16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] Sum,
  output logic        Co
);

  assign {Co, Sum} = {1'b0, A} + {1'b0, B} + {16'b0, Ci};

endmodule

// File: rtl/adder64_seq_ctrl.sv
// WIDTH-bit add/sub run over one shared Adder16bit, one slice per cycle.
// Ports: clk, rst_n, in_valid/in_ready + A/B/Ci/Sub,
//        out_valid/out_ready + Sum/Co/Ovf, busy.
module adder64_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             Ovf,
  output logic             busy
);

  localparam int NS = nslice(WIDTH);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] s_a, s_b, s_sum;
  logic               s_co;
  logic               accept;

  assign s_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign s_b = b_q[idx_q*SLICE_W +: SLICE_W];

  Adder16bit u_slice (
    .A   (s_a),
    .B   (s_b),
    .Ci  (c_q),
    .Sum (s_sum),
    .Co  (s_co)
  );

  // DONE forwards out_ready so a new op can start on handoff
  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign accept    = in_valid && in_ready;
  assign Sum       = sum_q;
  assign Co        = co_q;
  assign Ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = A;
          b_d     = Sub ? ~B : B;
          c_d     = Ci;
          idx_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
        c_d   = s_co;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          co_d    = s_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (s_sum[SLICE_W-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// Directed bench for adder64_seq_ctrl: latency, carry/overflow
// corners, subtract, DONE stall, back-to-back and mid-run reset.
module tb_adder64_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A, B;
  logic        Ci, Sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] Sum;
  logic        Co, Ovf, busy;

  int n_cmp = 0;
  int n_err = 0;

  adder64_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Co        (Co),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive a request and wait for the accepting edge
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic sub);
    int k;
    A = a; B = b; Ci = ci; Sub = sub;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // count edges until out_valid, then check result
  task automatic await_res(input string tag,
                           input logic [63:0] es,
                           input logic eco, input logic eov);
    int cnt;
    cnt = 0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_lat"}, 64'(cnt), 64'd4);
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_co"}, 64'(Co), 64'(eco));
    chk({tag, "_ovf"}, 64'(Ovf), 64'(eov));
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic ci, input logic sub,
                     input logic [63:0] es,
                     input logic eco, input logic eov);
    issue(a, b, ci, sub);
    await_res(tag, es, eco, eov);
    handoff(tag);
  endtask

  initial begin
    logic [63:0] hs;
    logic        hc, ho;
    logic        seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0; B = '0; Ci = 1'b0; Sub = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", Sum, 64'd0);
    chk("rst_co", 64'(Co), 64'd0);
    chk("rst_ovf", 64'(Ovf), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    run("t1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'd0, 1'b1, 1'b0);
    run("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run("t4a", 64'd5, 64'd7, 1'b1, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run("t4b", 64'd7, 64'd5, 1'b1, 1'b1,
        64'd2, 1'b1, 1'b0);

    // DONE stall, then back-to-back accept on handoff
    issue(64'd123, 64'd456, 1'b0, 1'b0);
    await_res("t5", 64'd579, 1'b0, 1'b0);
    hs = Sum; hc = Co; ho = Ovf;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_ov", 64'(out_valid), 64'd1);
      chk("t5_hold_rdy", 64'(in_ready), 64'd0);
      chk("t5_hold_sum", Sum, hs);
      chk("t5_hold_co", 64'(Co), 64'(hc));
      chk("t5_hold_ovf", 64'(Ovf), 64'(ho));
    end
    A = 64'd10; B = 64'd20; Ci = 1'b1; Sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t5_b2b_rdy", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t5_b2b_ov", 64'(out_valid), 64'd0);
    await_res("t5b", 64'd31, 1'b0, 1'b0);
    handoff("t5b");

    // reset in the 2nd RUN cycle aborts the op
    issue(64'h1111_2222_3333_4444, 64'h0000_FFFF_0000_FFFF,
          1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rdy", 64'(in_ready), 64'd1);
    chk("t6_rst_sum", Sum, 64'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("t6_no_ov", 64'(seen), 64'd0);
    run("t6", 64'h1111_2222_3333_4444, 64'h0000_FFFF_0000_FFFF,
        1'b0, 1'b0, 64'h1112_2221_3334_4443, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
